bitstream_packer: RTL and testbench
===================================

Name: bitstream_packer

Overview:
- Encoder-side bitstream writer: accepts variable-length codes (1–16 bits) from the entropy-coding stage.
- Packs them MSB-first into 16-bit words and writes them sequentially into the bitstream RAM.
- Bit order and word layout match what the decoder's bitstream buffer expects when it reads the same RAM back.
- A flush request zero-pads the final partial word and writes it out.

Parameters:
- ADDR_W, 17, width of the RAM word address.
- START_ADDR, 0, address of the first word written after reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- code_valid  input  1  code_value/code_len valid this cycle.
- code_value  input  16  code bits, right-aligned; bits above code_len ignored.
- code_len  input  5  number of valid bits, 0..16.
- code_ready  output  1  packer accepts a code this cycle.
- flush  input  1  pulse: pad and emit the residual bits.
- flush_done  output  1  one-cycle pulse when the flush completes.
- ram_wen  output  1  RAM write enable, one word per cycle.
- ram_addr  output  ADDR_W  RAM write address.
- ram_wdata  output  16  word written; bit 15 is the earliest bit in the stream.
- overflow  output  1  sticky: a word was dropped because the address space was exhausted.

Behaviour:
- Reset (asynchronous, reset_n low):
  - Outputs: code_ready=0, flush_done=0, ram_wen=0, ram_wdata=0, ram_addr=START_ADDR, overflow=0.
  - Internal: accumulator cleared, bit_cnt=0, state=RUN.
  - Any partial word is discarded; reset mid-operation loses residual bits, with no write.
- Internal state:
  - 32-bit accumulator, left-aligned.
  - 5-bit bit_cnt (0..31).
  - FSM with states RUN, FLUSH.
- Handshake: code_ready = (state==RUN), combinational. A code is accepted when code_valid && code_ready.
- Accept (cycle t):
  - code_value[code_len-1:0] is appended directly after the existing bit_cnt bits.
  - If bit_cnt+code_len >= 16: the top 16 accumulator bits are registered onto ram_wdata with ram_wen=1 in cycle t+1. The accumulator shifts left by 16 and bit_cnt = bit_cnt+code_len-16.
  - Otherwise: bit_cnt += code_len and ram_wen=0 in t+1.
  - Because bit_cnt<16 after every cycle, at most one word is produced per cycle and no backpressure is needed in RUN.
- Code length rules:
  - code_len=0: accepted, no effect.
  - code_len 17..31: illegal; the packer treats it as 16.
- ram_wen is a one-cycle pulse per word; ram_wdata holds its value between writes.
- Addressing:
  - ram_addr is valid whenever ram_wen=1 and increments by 1 in the cycle after each write.
  - No wrap-around. A write at address 2^ADDR_W-1 is performed, then ram_addr stays there.
  - Every further word is dropped (ram_wen held 0) and overflow is set, sticky until reset.
- Flush:
  - flush sampled in RUN at cycle t. If code_valid is also accepted in t, the code is appended first.
  - State goes to FLUSH in t+1, where code_ready=0.
  - In cycle t+1:
    - If bit_cnt>0: residual bits are left-aligned, low bits zero-padded, written with ram_wen=1 in t+2; bit_cnt becomes 0.
    - If bit_cnt==0: no write.
  - flush_done=1 in t+2 in both cases; state returns to RUN (code_ready=1 in t+2).
  - A full word produced by the cycle-t code is written in t+1, and the pad word in t+2: never two writes in one cycle.
  - flush asserted while in FLUSH is ignored.

Test Plan:
- Reset, then codes (0b101,len 3) then (0x1FFF,len 13) on consecutive cycles -> single write ram_wdata=0xBFFF at ram_addr=0, one cycle after the second code; no other ram_wen.
- Codes (0xABCD,16),(0x1234,16) back-to-back -> writes 0xABCD@0 and 0x1234@1 on consecutive cycles; code_ready stays 1; code_value=0xFFFF with len 4 then len 12 of 0x000 -> 0xF000 (upper bits masked).
- Code (0b11,2) then flush -> code_ready=0 for one cycle, write 0xC000@0, flush_done=1 in the same cycle as ram_wen; flush with bit_cnt=0 -> flush_done=1 two cycles later, no write.
- Code (0xFFFF,16) with flush in the same cycle after 8 residual bits (0xAA,len 8 earlier) -> write 0xAAFF then 0xFF00 on consecutive cycles, flush_done with the second.
- START_ADDR=131070, ADDR_W=17, write three full words -> writes at 131070 and 131071; third dropped (no ram_wen), overflow=1, ram_addr stays 131071.
- Accumulate 7 bits, assert reset_n low asynchronously mid-cycle -> all outputs return to reset values immediately. After release, (0x8000,16) -> write 0x8000@START_ADDR with no stale bits.

Source files
------------

// File: rtl/bitstream_packer.sv
// Packs 1..16-bit codes MSB-first into 16-bit words and writes them to the bitstream RAM.
// A flush zero-pads the residual bits into one final word.
module bitstream_packer #(
    parameter int          ADDR_W     = 17,
    parameter int unsigned START_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              code_valid,
    input  logic [15:0]       code_value,
    input  logic [4:0]        code_len,
    output logic              code_ready,
    input  logic              flush,
    output logic              flush_done,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_wdata,
    output logic              overflow
);

    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [ADDR_W-1:0] ADDR_INIT = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    state_t            state_q, state_d;
    logic [31:0]       acc_q, acc_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic              ram_wen_q, ram_wen_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [15:0]       ram_wdata_q, ram_wdata_d;
    logic              flush_done_q, flush_done_d;
    logic              overflow_q, overflow_d;
    logic              exhausted_q, exhausted_d;

    logic              accept;
    logic [4:0]        len;
    logic [5:0]        total;
    logic [5:0]        shamt;
    logic [31:0]       acc_new;
    logic              emit;
    logic [15:0]       emit_word;

    // Lengths above 16 are clamped to a full 16-bit code.
    function automatic logic [4:0] sat_len(input logic [4:0] l);
        return (l > 5'd16) ? 5'd16 : l;
    endfunction

    function automatic logic [15:0] mask_code(input logic [15:0] v, input logic [4:0] l);
        return v & (16'hFFFF >> (5'd16 - l));
    endfunction

    assign code_ready = reset_n && (state_q == RUN);
    assign accept     = code_valid && code_ready;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        bit_cnt_d    = bit_cnt_q;
        ram_wen_d    = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        flush_done_d = 1'b0;
        overflow_d   = overflow_q;
        exhausted_d  = exhausted_q;
        len          = sat_len(code_len);
        total        = {1'b0, bit_cnt_q} + {1'b0, len};
        shamt        = 6'd32 - total;
        acc_new      = acc_q | ({16'b0, mask_code(code_value, len)} << shamt);
        emit         = 1'b0;
        emit_word    = '0;

        // The address advances after each write; the last address is never left.
        if (ram_wen_q) begin
            if (ram_addr_q == ADDR_LAST) exhausted_d = 1'b1;
            else                         ram_addr_d  = ram_addr_q + 1'b1;
        end

        case (state_q)
            RUN: begin
                if (accept) begin
                    if (total >= 6'd16) begin
                        emit      = 1'b1;
                        emit_word = acc_new[31:16];
                        acc_d     = acc_new << 16;
                        bit_cnt_d = 5'(total - 6'd16);
                    end else begin
                        acc_d     = acc_new;
                        bit_cnt_d = total[4:0];
                    end
                end
                if (flush) state_d = FLUSH;
            end
            FLUSH: begin
                // Bits below the residual are always zero, so the top half is already padded.
                if (bit_cnt_q != 5'd0) begin
                    emit      = 1'b1;
                    emit_word = acc_q[31:16];
                end
                acc_d        = '0;
                bit_cnt_d    = '0;
                flush_done_d = 1'b1;
                state_d      = RUN;
            end
            default: state_d = RUN;
        endcase

        if (emit) begin
            if (exhausted_d) begin
                overflow_d = 1'b1;
            end else begin
                ram_wen_d   = 1'b1;
                ram_wdata_d = emit_word;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RUN;
            acc_q        <= '0;
            bit_cnt_q    <= '0;
            ram_wen_q    <= 1'b0;
            ram_addr_q   <= ADDR_INIT;
            ram_wdata_q  <= '0;
            flush_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            exhausted_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            bit_cnt_q    <= bit_cnt_d;
            ram_wen_q    <= ram_wen_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            flush_done_q <= flush_done_d;
            overflow_q   <= overflow_d;
            exhausted_q  <= exhausted_d;
        end
    end

    assign ram_wen    = ram_wen_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign flush_done = flush_done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_bitstream_packer.sv
// Directed bench for bitstream_packer: expected RAM writes are queued when codes are driven
// and popped whenever a DUT write appears; a second instance covers the end of the address space.
module tb_bitstream_packer;

    typedef struct packed {
        logic [16:0] addr;
        logic [15:0] data;
    } wr_t;

    logic        clk;
    logic        reset_n;
    logic        code_valid, flush;
    logic [15:0] code_value;
    logic [4:0]  code_len;
    logic        code_ready, flush_done, ram_wen, overflow;
    logic [16:0] ram_addr;
    logic [15:0] ram_wdata;

    logic        c2_valid, c2_flush;
    logic [15:0] c2_value;
    logic [4:0]  c2_len;
    logic        c2_ready, c2_flush_done, c2_wen, c2_overflow;
    logic [16:0] c2_addr;
    logic [15:0] c2_wdata;

    wr_t exp_q[$];
    int  n_assert;
    int  n_fail;

    bitstream_packer #(.ADDR_W(17), .START_ADDR(0)) dut (
        .clk(clk), .reset_n(reset_n),
        .code_valid(code_valid), .code_value(code_value), .code_len(code_len),
        .code_ready(code_ready), .flush(flush), .flush_done(flush_done),
        .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .overflow(overflow)
    );

    bitstream_packer #(.ADDR_W(17), .START_ADDR(131070)) dut_top (
        .clk(clk), .reset_n(reset_n),
        .code_valid(c2_valid), .code_value(c2_value), .code_len(c2_len),
        .code_ready(c2_ready), .flush(c2_flush), .flush_done(c2_flush_done),
        .ram_wen(c2_wen), .ram_addr(c2_addr), .ram_wdata(c2_wdata), .overflow(c2_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Advance one clock, then compare any write the main instance makes against the queue.
    task automatic tick();
        wr_t w;
        @(posedge clk);
        #1;
        if (ram_wen === 1'b1) begin
            chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                chk("wr_addr", 32'(ram_addr), 32'(w.addr));
                chk("wr_data", 32'(ram_wdata), 32'(w.data));
            end
        end
    endtask

    task automatic expect_wr(input logic [16:0] a, input logic [15:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic send(input logic [15:0] v, input logic [4:0] l);
        code_valid = 1'b1;
        code_value = v;
        code_len   = l;
        tick();
        code_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        code_valid = 1'b0;
        flush      = 1'b0;
        code_value = '0;
        code_len   = '0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        c2_valid = 1'b0;
        c2_flush = 1'b0;
        c2_value = '0;
        c2_len   = '0;
        do_reset();

        // Reset values, then code_ready once reset is released.
        reset_n = 1'b0;
        #1;
        chk("rst_code_ready", 32'(code_ready), 32'd0);
        chk("rst_ram_wen", 32'(ram_wen), 32'd0);
        chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_flush_done", 32'(flush_done), 32'd0);
        chk("rst_addr_top", 32'(c2_addr), 32'd131070);
        tick();
        reset_n = 1'b1;
        #1;
        chk("ready_after_rst", 32'(code_ready), 32'd1);

        // 3 + 13 bits make exactly one word.
        send(16'h0005, 5'd3);
        chk("t1_no_early_write", 32'(ram_wen), 32'd0);
        expect_wr(17'd0, 16'hBFFF);
        send(16'h1FFF, 5'd13);
        chk("t1_write_done", 32'(exp_q.size()), 32'd0);
        tick();
        tick();

        // Back-to-back full words, masking, zero-length and over-length codes.
        do_reset();
        expect_wr(17'd0, 16'hABCD);
        send(16'hABCD, 5'd16);
        chk("t2_ready0", 32'(code_ready), 32'd1);
        expect_wr(17'd1, 16'h1234);
        send(16'h1234, 5'd16);
        chk("t2_ready1", 32'(code_ready), 32'd1);
        chk("t2_two_writes", 32'(exp_q.size()), 32'd0);
        send(16'hFFFF, 5'd4);
        send(16'hFFFF, 5'd0);
        chk("t2_len0_no_write", 32'(ram_wen), 32'd0);
        expect_wr(17'd2, 16'hF000);
        send(16'hF000, 5'd12);
        expect_wr(17'd3, 16'h5A5A);
        send(16'h5A5A, 5'd20);
        tick();
        chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("t2_wdata_held", 32'(ram_wdata), 32'h5A5A);

        // Flush with two residual bits, then flush with none.
        do_reset();
        send(16'h0003, 5'd2);
        flush = 1'b1;
        expect_wr(17'd0, 16'hC000);
        tick();
        flush = 1'b0;
        chk("t3_ready_in_flush", 32'(code_ready), 32'd0);
        chk("t3_no_done_yet", 32'(flush_done), 32'd0);
        tick();
        chk("t3_flush_done", 32'(flush_done), 32'd1);
        chk("t3_wen_with_done", 32'(ram_wen), 32'd1);
        chk("t3_ready_back", 32'(code_ready), 32'd1);
        chk("t3_pad_written", 32'(exp_q.size()), 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t3b_ready_in_flush", 32'(code_ready), 32'd0);
        tick();
        chk("t3b_flush_done", 32'(flush_done), 32'd1);
        chk("t3b_no_write", 32'(ram_wen), 32'd0);
        tick();
        chk("t3b_done_pulse", 32'(flush_done), 32'd0);

        // Full word and pad word from one cycle: consecutive, never together.
        do_reset();
        send(16'h00AA, 5'd8);
        expect_wr(17'd0, 16'hAAFF);
        expect_wr(17'd1, 16'hFF00);
        flush = 1'b1;
        send(16'hFFFF, 5'd16);
        flush = 1'b0;
        chk("t4_first_wen", 32'(ram_wen), 32'd1);
        chk("t4_done_not_first", 32'(flush_done), 32'd0);
        tick();
        chk("t4_second_wen", 32'(ram_wen), 32'd1);
        chk("t4_done_second", 32'(flush_done), 32'd1);
        chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);

        // End of address space on the second instance.
        c2_valid = 1'b1;
        c2_len   = 5'd16;
        c2_value = 16'h1111;
        tick();
        chk("t5_wen0", 32'(c2_wen), 32'd1);
        chk("t5_addr0", 32'(c2_addr), 32'd131070);
        chk("t5_data0", 32'(c2_wdata), 32'h1111);
        c2_value = 16'h2222;
        tick();
        chk("t5_wen1", 32'(c2_wen), 32'd1);
        chk("t5_addr1", 32'(c2_addr), 32'd131071);
        chk("t5_data1", 32'(c2_wdata), 32'h2222);
        chk("t5_no_ovf_yet", 32'(c2_overflow), 32'd0);
        c2_value = 16'h3333;
        tick();
        c2_valid = 1'b0;
        chk("t5_dropped", 32'(c2_wen), 32'd0);
        chk("t5_overflow", 32'(c2_overflow), 32'd1);
        chk("t5_addr_stays", 32'(c2_addr), 32'd131071);
        tick();
        chk("t5_overflow_sticky", 32'(c2_overflow), 32'd1);
        chk("t5_addr_still", 32'(c2_addr), 32'd131071);

        // Asynchronous reset mid-cycle discards the residual bits.
        do_reset();
        expect_wr(17'd0, 16'hABCD);
        send(16'hABCD, 5'd16);
        send(16'h007F, 5'd7);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t6_async_wdata", 32'(ram_wdata), 32'd0);
        chk("t6_async_addr", 32'(ram_addr), 32'd0);
        chk("t6_async_ready", 32'(code_ready), 32'd0);
        chk("t6_async_wen", 32'(ram_wen), 32'd0);
        chk("t6_async_ovf_top", 32'(c2_overflow), 32'd0);
        tick();
        reset_n = 1'b1;
        expect_wr(17'd0, 16'h8000);
        send(16'h8000, 5'd16);
        chk("t6_clean_word", 32'(exp_q.size()), 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
